// File: rtl/axis_pkt_player.sv
// ---------------------------------------------------------------------------
// axis_pkt_player
//   Replays packets held in an internal beat memory onto an AXI4-Stream
//   master port. A table of PKT_SLOTS slot descriptors (start, len, tuser,
//   gap) is walked in order, and the whole sequence is repeated
//   repeat_cnt+1 times. Honours m_axis_tready backpressure and keeps
//   saturating packet, beat and stall counters.
//
//   Optional feature macro: AXIS_PLAYER_SEQNUM_EN
//     When defined, tuser[31:0] of each packet's first beat carries a 32-bit
//     packet sequence number that restarts at 0 on every start.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   beat_wr_*                beat memory write (ignored while busy)
//   slot_wr_*                slot descriptor write (ignored while busy)
//   start, repeat_cnt        begin playback, extra passes (sampled at start)
//   abort                    stop at the next packet boundary
//   busy, done               playback status, end-of-playback pulse
//   m_axis_*                 AXI4-Stream master
//   pkt_cnt, beat_cnt,
//   stall_cnt                saturating statistics
// ---------------------------------------------------------------------------
module axis_pkt_player #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int BEAT_DEPTH         = 64,
    parameter int PKT_SLOTS          = 4,
    parameter int GAP_WIDTH          = 8,
    localparam int KW = C_AXIS_DATA_WIDTH / 8,
    localparam int BA = $clog2(BEAT_DEPTH),
    localparam int SA = $clog2(PKT_SLOTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_wr_en,
    input  logic [BA-1:0]                 beat_wr_addr,
    input  logic [C_AXIS_DATA_WIDTH-1:0]  beat_wr_data,
    input  logic [KW-1:0]                 beat_wr_keep,
    input  logic                          slot_wr_en,
    input  logic [SA-1:0]                 slot_wr_idx,
    input  logic [BA-1:0]                 slot_wr_start,
    input  logic [BA:0]                   slot_wr_len,
    input  logic [C_AXIS_TUSER_WIDTH-1:0] slot_wr_tuser,
    input  logic [GAP_WIDTH-1:0]          slot_wr_gap,
    input  logic                          start,
    input  logic [15:0]                   repeat_cnt,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic [C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [KW-1:0]                 m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   pkt_cnt,
    output logic [31:0]                   beat_cnt,
    output logic [31:0]                   stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DRAIN} state_t;

    // Storage
    logic [C_AXIS_DATA_WIDTH-1:0]  r_mem_data   [BEAT_DEPTH];
    logic [KW-1:0]                 r_mem_keep   [BEAT_DEPTH];
    logic [BA-1:0]                 r_slot_start [PKT_SLOTS];
    logic [BA:0]                   r_slot_len   [PKT_SLOTS];
    logic [C_AXIS_TUSER_WIDTH-1:0] r_slot_tuser [PKT_SLOTS];
    logic [GAP_WIDTH-1:0]          r_slot_gap   [PKT_SLOTS];

    // 2-entry output FIFO; entries are loaded straight from the beat memory,
    // which makes the memory read synchronous with a single cycle of latency.
    logic [C_AXIS_DATA_WIDTH-1:0]  r_fifo_data [2];
    logic [KW-1:0]                 r_fifo_keep [2];
    logic [C_AXIS_TUSER_WIDTH-1:0] r_fifo_user [2];
    logic                          r_fifo_last [2];
    logic                          r_wr_ptr, r_rd_ptr;
    logic [1:0]                    r_fifo_cnt;

    // Control state
    state_t          r_state, w_state_nxt;
    logic [SA-1:0]   r_slot;
    logic [BA:0]     r_beat_idx;
    logic [15:0]     r_pass_left;
    logic [GAP_WIDTH-1:0] r_gap_cnt;
    logic            r_abort_req;
    logic [31:0]     r_pkt_cnt, r_beat_cnt, r_stall_cnt;

    logic                          w_idle, w_start_acc, w_tvalid, w_pop, w_room;
    logic                          w_issue, w_last_beat, w_boundary, w_empty_next;
    logic                          w_abort_any, w_done, w_goto_next, w_enter_gap, w_gap_tick;
    logic                          w_nxt_found, w_nxt_wrap;
    logic [SA-1:0]                 w_nxt_slot;
    logic [BA-1:0]                 w_rd_addr;
    logic [BA:0]                   w_cur_len;
    logic [GAP_WIDTH-1:0]          w_cur_gap;
    logic [C_AXIS_TUSER_WIDTH-1:0] w_first_tuser, w_beat_tuser;

    assign w_idle      = (r_state == S_IDLE);
    assign w_start_acc = w_idle && start;
    assign w_cur_len   = r_slot_len[r_slot];
    assign w_cur_gap   = r_slot_gap[r_slot];
    // Slot addresses wrap naturally through the BA-bit sum.
    assign w_rd_addr   = r_slot_start[r_slot] + r_beat_idx[BA-1:0];
    assign w_last_beat = (r_beat_idx == w_cur_len - (BA+1)'(1));
    assign w_tvalid    = (r_fifo_cnt != 2'd0);
    assign w_pop       = w_tvalid && m_axis_tready;
    // A new read may be issued whenever the FIFO will have a free entry at
    // the coming edge; a pop in the same cycle frees one.
    assign w_room      = (r_fifo_cnt != 2'd2) || w_pop;
    assign w_issue     = (r_state == S_PLAY) && (w_cur_len != '0) && w_room;
    assign w_boundary  = (w_cur_len == '0) || (w_issue && w_last_beat);
    // FIFO is empty after this edge: the slot's last beat has handshaken.
    assign w_empty_next = (r_fifo_cnt == 2'd0) || ((r_fifo_cnt == 2'd1) && w_pop);
    assign w_abort_any = abort || r_abort_req;
    assign w_beat_tuser = (r_beat_idx == '0) ? w_first_tuser : '0;

    // Memories and descriptors only change while idle so playback sees a
    // frozen image.
    // NOTE: storage arrays carry no reset; only control state needs a known
    // value, and resetting an array prevents RAM inference.
    always_ff @(posedge clk) begin
        if (beat_wr_en && w_idle) begin
            r_mem_data[beat_wr_addr] <= beat_wr_data;
            r_mem_keep[beat_wr_addr] <= beat_wr_keep;
        end
        if (slot_wr_en && w_idle) begin
            r_slot_start[slot_wr_idx] <= slot_wr_start;
            r_slot_len[slot_wr_idx]   <= slot_wr_len;
            r_slot_tuser[slot_wr_idx] <= slot_wr_tuser;
            r_slot_gap[slot_wr_idx]   <= slot_wr_gap;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fifo_data[r_wr_ptr] <= r_mem_data[w_rd_addr];
            r_fifo_keep[r_wr_ptr] <= r_mem_keep[w_rd_addr];
            r_fifo_user[r_wr_ptr] <= w_beat_tuser;
            r_fifo_last[r_wr_ptr] <= w_last_beat;
        end
    end

`ifdef AXIS_PLAYER_SEQNUM_EN
    logic [31:0] r_seq;

    always_comb begin
        w_first_tuser        = r_slot_tuser[r_slot];
        w_first_tuser[31:0]  = r_seq;
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_seq <= '0;
        end else if (w_issue && (r_beat_idx == '0)) begin
            r_seq <= r_seq + 32'd1;
        end
    end
`else
    assign w_first_tuser = r_slot_tuser[r_slot];
`endif

    // Next enabled slot after the current one; wraps into a new pass only
    // when passes remain. Descending scan so the lowest index wins.
    always_comb begin
        w_nxt_found = 1'b0;
        w_nxt_wrap  = 1'b0;
        w_nxt_slot  = '0;
        for (int j = PKT_SLOTS - 1; j >= 0; j--) begin
            if ((j > int'(r_slot)) && (r_slot_len[j] != '0)) begin
                w_nxt_found = 1'b1;
                w_nxt_slot  = SA'(j);
            end
        end
        if (!w_nxt_found && (r_pass_left != 16'd0)) begin
            for (int j = PKT_SLOTS - 1; j >= 0; j--) begin
                if (r_slot_len[j] != '0) begin
                    w_nxt_found = 1'b1;
                    w_nxt_wrap  = 1'b1;
                    w_nxt_slot  = SA'(j);
                end
            end
        end
    end

    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no path leaves a value held (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_goto_next = 1'b0;
        w_enter_gap = 1'b0;
        w_gap_tick  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (w_boundary) begin
                    if (w_abort_any || !w_nxt_found) begin
                        w_state_nxt = S_DRAIN;
                    end else if ((w_cur_len != '0) && (w_cur_gap != '0)) begin
                        w_state_nxt = S_GAP;
                        w_enter_gap = 1'b1;
                    end else begin
                        w_goto_next = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (w_abort_any) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_empty_next) begin
                    if (r_gap_cnt == GAP_WIDTH'(1)) begin
                        w_state_nxt = S_PLAY;
                        w_goto_next = 1'b1;
                    end else begin
                        w_gap_tick = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (r_fifo_cnt == 2'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_fifo_cnt  <= 2'd0;
            r_slot      <= '0;
            r_beat_idx  <= '0;
            r_pass_left <= '0;
            r_gap_cnt   <= '0;
            r_abort_req <= 1'b0;
            r_pkt_cnt   <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
            case ({w_issue, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            if (w_start_acc) begin
                r_slot      <= '0;
                r_beat_idx  <= '0;
                r_pass_left <= repeat_cnt;
                r_abort_req <= 1'b0;
                r_pkt_cnt   <= '0;
                r_beat_cnt  <= '0;
                r_stall_cnt <= '0;
            end else begin
                if (w_goto_next) begin
                    r_slot     <= w_nxt_slot;
                    r_beat_idx <= '0;
                    if (w_nxt_wrap) r_pass_left <= r_pass_left - 16'd1;
                end else if (w_issue) begin
                    r_beat_idx <= r_beat_idx + (BA+1)'(1);
                end

                if (w_enter_gap)     r_gap_cnt <= w_cur_gap;
                else if (w_gap_tick) r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);

                if (w_state_nxt == S_IDLE)       r_abort_req <= 1'b0;
                else if (abort && !w_idle)       r_abort_req <= 1'b1;

                if (w_pop && (r_beat_cnt != '1)) r_beat_cnt <= r_beat_cnt + 32'd1;
                if (w_pop && r_fifo_last[r_rd_ptr] && (r_pkt_cnt != '1))
                    r_pkt_cnt <= r_pkt_cnt + 32'd1;
                if (w_tvalid && !m_axis_tready && (r_stall_cnt != '1))
                    r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    // Outputs are gated by valid so idle/reset presents all-zero fields.
    assign m_axis_tvalid = w_tvalid;
    assign m_axis_tdata  = w_tvalid ? r_fifo_data[r_rd_ptr] : '0;
    assign m_axis_tkeep  = w_tvalid ? r_fifo_keep[r_rd_ptr] : '0;
    assign m_axis_tuser  = w_tvalid ? r_fifo_user[r_rd_ptr] : '0;
    assign m_axis_tlast  = w_tvalid && r_fifo_last[r_rd_ptr];
    assign done          = w_done;
    assign busy          = !w_idle && !w_done;
    assign pkt_cnt       = r_pkt_cnt;
    assign beat_cnt      = r_beat_cnt;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_axis_pkt_player.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_player
//   Directed bench for axis_pkt_player (32-bit data, 32-bit tuser, 64 beats,
//   4 slots). A cycle table covers the single-packet timing; hand sequences
//   cover gaps/repeats, backpressure, address wrap, abort, mid-packet reset
//   and an all-disabled slot table. Expected beats come from a small model
//   built from the memory pattern and the descriptors written by the bench.
//   Honours AXIS_PLAYER_SEQNUM_EN for the expected first-beat tuser.
// ---------------------------------------------------------------------------
module tb_axis_pkt_player;

    localparam int DW = 32;
    localparam int UW = 32;
    localparam int BD = 64;
    localparam int PS = 4;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          beat_wr_en;
    logic [5:0]    beat_wr_addr;
    logic [31:0]   beat_wr_data;
    logic [3:0]    beat_wr_keep;
    logic          slot_wr_en;
    logic [1:0]    slot_wr_idx;
    logic [5:0]    slot_wr_start;
    logic [6:0]    slot_wr_len;
    logic [31:0]   slot_wr_tuser;
    logic [7:0]    slot_wr_gap;
    logic          start;
    logic [15:0]   repeat_cnt;
    logic          abort;
    logic          busy, done;
    logic [31:0]   m_axis_tdata;
    logic [3:0]    m_axis_tkeep;
    logic [31:0]   m_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [31:0]   pkt_cnt, beat_cnt, stall_cnt;

    axis_pkt_player #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .BEAT_DEPTH        (BD),
        .PKT_SLOTS         (PS),
        .GAP_WIDTH         (GW)
    ) dut (
        .clk(clk), .rst(rst),
        .beat_wr_en(beat_wr_en), .beat_wr_addr(beat_wr_addr),
        .beat_wr_data(beat_wr_data), .beat_wr_keep(beat_wr_keep),
        .slot_wr_en(slot_wr_en), .slot_wr_idx(slot_wr_idx),
        .slot_wr_start(slot_wr_start), .slot_wr_len(slot_wr_len),
        .slot_wr_tuser(slot_wr_tuser), .slot_wr_gap(slot_wr_gap),
        .start(start), .repeat_cnt(repeat_cnt), .abort(abort),
        .busy(busy), .done(done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat_data(input int a);
        return 32'hC0DE_0000 + 32'(a * 257);
    endfunction

    function automatic logic [3:0] pat_keep(input int a);
        return 4'(a ^ 15);
    endfunction

    // Bench-side copy of the descriptors it has written
    int          sl_start [PS];
    int          sl_len   [PS];
    int          sl_gap   [PS];
    logic [31:0] sl_user  [PS];

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic [31:0] user;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    int    exp_gaps[$];
    int    got_gaps[$];
    int    done_cyc, last_xfer_cyc, stalls_seen;

    task automatic write_slot(input int idx, input int st, input int len, input int gap);
        @(negedge clk);
        slot_wr_en    = 1'b1;
        slot_wr_idx   = 2'(idx);
        slot_wr_start = 6'(st);
        slot_wr_len   = 7'(len);
        slot_wr_gap   = 8'(gap);
        slot_wr_tuser = 32'h5500_0000 + 32'(idx * 16 + len);
        sl_start[idx] = st;
        sl_len[idx]   = len;
        sl_gap[idx]   = gap;
        sl_user[idx]  = slot_wr_tuser;
        @(negedge clk);
        slot_wr_en = 1'b0;
    endtask

    task automatic load_mem();
        for (int a = 0; a < BD; a++) begin
            @(negedge clk);
            beat_wr_en   = 1'b1;
            beat_wr_addr = 6'(a);
            beat_wr_data = pat_data(a);
            beat_wr_keep = pat_keep(a);
        end
        @(negedge clk);
        beat_wr_en = 1'b0;
    endtask

    // Expected beat stream for rep+1 passes, truncated to max_pkts packets.
    task automatic build_exp(input int rep, input int max_pkts);
        int    npk;
        int    prev_gap;
        beat_t b;
        exp_q.delete();
        exp_gaps.delete();
        npk = 0;
        prev_gap = 0;
        for (int p = 0; p <= rep; p++) begin
            for (int s = 0; s < PS; s++) begin
                if (sl_len[s] != 0 && npk < max_pkts) begin
                    if (npk > 0) exp_gaps.push_back(prev_gap);
                    for (int k = 0; k < sl_len[s]; k++) begin
                        b.data = pat_data((sl_start[s] + k) % BD);
                        b.keep = pat_keep((sl_start[s] + k) % BD);
                        b.last = (k == sl_len[s] - 1);
`ifdef AXIS_PLAYER_SEQNUM_EN
                        b.user = (k == 0) ? 32'(npk) : 32'h0;
`else
                        b.user = (k == 0) ? sl_user[s] : 32'h0;
`endif
                        exp_q.push_back(b);
                    end
                    prev_gap = sl_gap[s];
                    npk++;
                end
            end
        end
    endtask

    // Runs one playback (start already driven for cycle 0) and records
    // transfers, idle gaps after each tlast, stalls and the done cycle.
    task automatic run_play(input int budget, input int ready_mode, input int abort_beat);
        beat_t cur, held;
        logic  held_valid, in_gap;
        int    idle;
        got_q.delete();
        got_gaps.delete();
        stalls_seen   = 0;
        done_cyc      = -1;
        last_xfer_cyc = -1;
        held_valid    = 1'b0;
        in_gap        = 1'b0;
        idle          = 0;
        held          = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                check("done_tvalid_low", m_axis_tvalid, 1'b0);
                break;
            end
            m_axis_tready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            abort = (abort_beat >= 0) && m_axis_tvalid && (got_q.size() == abort_beat);
            if (held_valid) check("hold_valid", m_axis_tvalid, 1'b1);
            if (m_axis_tvalid) begin
                cur = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser, last: m_axis_tlast};
                if (held_valid) check("hold_stable", cur, held);
                if (in_gap) begin
                    got_gaps.push_back(idle);
                    in_gap = 1'b0;
                end
                if (m_axis_tready) begin
                    got_q.push_back(cur);
                    held_valid    = 1'b0;
                    last_xfer_cyc = cyc;
                    if (m_axis_tlast) begin
                        in_gap = 1'b1;
                        idle   = 0;
                    end
                end else begin
                    stalls_seen++;
                    held       = cur;
                    held_valid = 1'b1;
                end
            end else if (in_gap) begin
                idle++;
            end
        end
        abort         = 1'b0;
        m_axis_tready = 1'b1;
        check("done_seen", done_cyc >= 0, 1'b1);
    endtask

    task automatic compare_run(input string name);
        check({name, "_nbeats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        check({name, "_ngaps"}, got_gaps.size(), exp_gaps.size());
        for (int i = 0; i < exp_gaps.size() && i < got_gaps.size(); i++)
            check($sformatf("%s_gap%0d", name, i), got_gaps[i], exp_gaps[i]);
        if (exp_q.size() > 0) check({name, "_done_lat"}, done_cyc, last_xfer_cyc + 1);
    endtask

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        ev;
        logic        el;
        logic [31:0] ed;
        logic [31:0] eu;
        logic        eb;
        logic        edn;
    } vec_t;

`ifdef AXIS_PLAYER_SEQNUM_EN
    localparam logic [31:0] T1_USER = 32'h0;
`else
    localparam logic [31:0] T1_USER = 32'h5500_0004;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[8];
        int   xfers;

        rst = 1'b1; beat_wr_en = 1'b0; beat_wr_addr = '0; beat_wr_data = '0; beat_wr_keep = '0;
        slot_wr_en = 1'b0; slot_wr_idx = '0; slot_wr_start = '0; slot_wr_len = '0;
        slot_wr_tuser = '0; slot_wr_gap = '0; start = 1'b0; repeat_cnt = '0; abort = 1'b0;
        m_axis_tready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_tdata", m_axis_tdata, 32'h0);
        check("rst_tkeep", m_axis_tkeep, 4'h0);
        check("rst_tuser", m_axis_tuser, 32'h0);
        check("rst_pkt_cnt", pkt_cnt, 32'h0);
        check("rst_beat_cnt", beat_cnt, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        rst = 1'b0;

        load_mem();
        write_slot(0, 0, 4, 0);
        for (int s = 1; s < PS; s++) write_slot(s, 0, 0, 0);

        // Single 4-beat packet, cycle by cycle from the start pulse
        //           start ready ev  el  data           user     busy done
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE_0000, T1_USER, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE_0101, 32'h0,   1'b1, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hC0DE_0202, 32'h0,   1'b1, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hC0DE_0303, 32'h0,   1'b1, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,   1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t1_c%0d_tvalid", i), m_axis_tvalid, vt[i].ev);
            check($sformatf("t1_c%0d_tlast", i), m_axis_tlast, vt[i].el);
            check($sformatf("t1_c%0d_tdata", i), m_axis_tdata, vt[i].ed);
            check($sformatf("t1_c%0d_tuser", i), m_axis_tuser, vt[i].eu);
            check($sformatf("t1_c%0d_busy", i), busy, vt[i].eb);
            check($sformatf("t1_c%0d_done", i), done, vt[i].edn);
            start         = vt[i].start;
            m_axis_tready = vt[i].ready;
        end
        check("t1_pkt_cnt", pkt_cnt, 32'd1);
        check("t1_beat_cnt", beat_cnt, 32'd4);
        check("t1_stall_cnt", stall_cnt, 32'd0);

        // Two slots with gaps, two passes
        write_slot(0, 0, 2, 5);
        write_slot(1, 8, 3, 0);
        @(negedge clk); start = 1'b1; repeat_cnt = 16'd1;
        run_play(300, 0, -1);
        build_exp(1, 99);
        compare_run("t2");
        check("t2_pkt_cnt", pkt_cnt, 32'd4);
        check("t2_beat_cnt", beat_cnt, 32'd10);

        // Backpressure: tready toggling
        write_slot(0, 0, 4, 0);
        write_slot(1, 0, 0, 0);
        @(negedge clk); start = 1'b1; repeat_cnt = 16'd0;
        run_play(300, 1, -1);
        build_exp(0, 99);
        compare_run("t3");
        check("t3_stalls_present", stalls_seen > 0, 1'b1);
        check("t3_stall_cnt", stall_cnt, 32'(stalls_seen));
        check("t3_pkt_cnt", pkt_cnt, 32'd1);

        // Beat address wrap 62,63,0,1
        write_slot(0, 62, 4, 0);
        @(negedge clk); start = 1'b1;
        run_play(300, 0, -1);
        build_exp(0, 99);
        compare_run("t4");

        // Abort during beat 1 of slot 0; slot 1 must not play
        write_slot(0, 0, 4, 0);
        write_slot(1, 16, 2, 0);
        @(negedge clk); start = 1'b1;
        run_play(300, 0, 1);
        build_exp(0, 1);
        compare_run("t5");
        check("t5_pkt_cnt", pkt_cnt, 32'd1);

        // Reset in the middle of a packet, then replay
        write_slot(1, 0, 0, 0);
        @(negedge clk); start = 1'b1;
        xfers = 0;
        for (int c = 0; c < 50 && xfers < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_axis_tvalid && m_axis_tready) xfers++;
        end
        check("t6_reach_beat2", xfers, 2);
        @(negedge clk);
        check("t6_beat2_on_bus", m_axis_tdata, pat_data(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_tvalid", m_axis_tvalid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_pkt_cnt", pkt_cnt, 32'h0);
        check("t6_beat_cnt", beat_cnt, 32'h0);
        check("t6_stall_cnt", stall_cnt, 32'h0);
        start = 1'b1;
        run_play(300, 0, -1);
        build_exp(0, 99);
        compare_run("t6");

        // Every slot disabled: straight to done with no beats
        write_slot(0, 0, 0, 0);
        @(negedge clk); start = 1'b1;
        run_play(50, 0, -1);
        check("t7_nbeats", got_q.size(), 0);
        check("t7_done_cyc", done_cyc, 2);
        check("t7_beat_cnt", beat_cnt, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_pkt_player.md
# axis_pkt_player

Parametrised AXI4-Stream packet player for the RMT pipeline benches and on-chip self-test. It replays packets from an internal beat memory onto a master AXI-Stream port, so the pipeline input can be driven without hand-coded stimulus. It plays a configurable sequence of packet slots, each followed by its own idle gap, and repeats the sequence N times. It honours `m_axis_tready` backpressure and keeps packet, beat and stall counters.

## Interface
Parameters:
- `C_AXIS_DATA_WIDTH`, 512, tdata width; tkeep is `C_AXIS_DATA_WIDTH/8`.
- `C_AXIS_TUSER_WIDTH`, 128, tuser width; must be ≥ 32.
- `BEAT_DEPTH`, 64, beat-memory entries; power of two; `BA = log2(BEAT_DEPTH)`.
- `PKT_SLOTS`, 4, slot-descriptor entries; power of two; `SA = log2(PKT_SLOTS)`.
- `GAP_WIDTH`, 8, width of the per-slot idle-gap field.

Ports:
- `clk`, in, 1, sole clock.
- `rst`, in, 1, synchronous, active-high reset.
- `beat_wr_en`, in, 1, write one beat-memory entry.
- `beat_wr_addr`, in, BA, beat-memory address.
- `beat_wr_data`, in, C_AXIS_DATA_WIDTH, beat tdata.
- `beat_wr_keep`, in, C_AXIS_DATA_WIDTH/8, beat tkeep.
- `slot_wr_en`, in, 1, write one slot descriptor.
- `slot_wr_idx`, in, SA, slot index.
- `slot_wr_start`, in, BA, first beat address of the slot.
- `slot_wr_len`, in, BA+1, beat count; 0 means the slot is disabled.
- `slot_wr_tuser`, in, C_AXIS_TUSER_WIDTH, tuser for the slot's first beat.
- `slot_wr_gap`, in, GAP_WIDTH, idle cycles after the slot's last beat.
- `start`, in, 1, pulse that begins playback.
- `repeat_cnt`, in, 16, extra passes; sampled at `start`.
- `abort`, in, 1, stop after the current packet.
- `busy`, out, 1, playback in progress.
- `done`, out, 1, one-cycle pulse at end of playback.
- `m_axis_tdata`, out, C_AXIS_DATA_WIDTH, master stream data.
- `m_axis_tkeep`, out, C_AXIS_DATA_WIDTH/8, master stream keep.
- `m_axis_tuser`, out, C_AXIS_TUSER_WIDTH, master stream user.
- `m_axis_tvalid`, out, 1, master stream valid.
- `m_axis_tready`, in, 1, master stream ready.
- `m_axis_tlast`, out, 1, master stream last.
- `pkt_cnt`, out, 32, packets sent.
- `beat_cnt`, out, 32, beats sent.
- `stall_cnt`, out, 32, stalled cycles.

## Operation
- States: IDLE, PLAY, GAP, DRAIN.
  - IDLE: on `start` latch `repeat_cnt`, set slot=0, go to PLAY.
  - PLAY: fetch beats `start..start+len-1` of the current slot.
    - Addresses wrap modulo BEAT_DEPTH.
    - Slots with `len=0` are skipped with no output and no gap.
    - After the last beat is issued, go to GAP (if `gap>0`), otherwise to the next slot.
  - GAP: count `gap` cycles with no new beats issued. Counting starts after the slot's last beat handshakes.
  - DRAIN: entered after the final slot of the final pass, or after `abort`. Waits until the output stage is empty, then pulses `done` and returns to IDLE.
- Slot sequence runs 0..PKT_SLOTS-1 per pass, for `repeat_cnt+1` passes in total.
- Beat fields:
  - tuser equals `slot_wr_tuser` on the first beat of a packet and 0 on all other beats.
  - tlast is asserted on beat `len-1`; it is derived from `len`, not stored.
- Handshake rules:
  - A beat transfers when `m_axis_tvalid & m_axis_tready`.
  - Once tvalid is high, tdata/tkeep/tuser/tlast stay stable until the transfer.
  - tvalid never drops without a transfer.
- `abort` is honoured at packet boundaries only: the in-flight packet completes with tlast, then the block goes to DRAIN.
- `start` while busy is ignored.
- `beat_wr_en` and `slot_wr_en` while busy are ignored, so memory and descriptors are frozen during playback.
- If every slot has `len=0`: IDLE → PLAY → DRAIN with no beats, then `done`.
- Counters:
  - `pkt_cnt` increments on a tlast transfer.
  - `beat_cnt` increments on each transfer.
  - `stall_cnt` increments on each cycle with `tvalid & ~tready`.
  - All three saturate at all-ones and clear on `rst` or `start`.

## Timing
- Beat memory has a synchronous, 1-cycle read. It feeds a 2-entry output FIFO (skid buffer), which gives 1 beat/cycle throughput while tready is held high.
- `start` in cycle 0 → first tvalid in cycle 2.
- `busy` goes high in cycle 1 and falls in the same cycle as `done`.
- `done` occurs 1 cycle after the final beat's transfer.
- Back-to-back packets (gap=0, tready high): the next packet's first beat immediately follows the previous tlast beat.
- gap=G: exactly G cycles of tvalid low between a tlast transfer and the next first beat.
- Reset values, one cycle after `rst`:
  - tvalid, tlast, busy, done = 0.
  - tdata, tkeep, tuser = 0.
  - All counters = 0.
  - FSM = IDLE, output FIFO emptied.
  - Beat memory and descriptors are not reset.
- `rst` mid-packet truncates the packet (no tlast); this is the only legal truncation.

## Configuration
- `AXIS_PLAYER_SEQNUM_EN` defined: on each packet's first beat, `tuser[31:0]` is replaced with a 32-bit packet sequence number. The number starts at 0 on `start` and increments per packet, so duplicates and drops are detectable downstream.
- `AXIS_PLAYER_SEQNUM_EN` undefined: tuser is passed through unmodified and the sequence counter is not built.

## Test plan
- 4-beat packet in slot 0 (start=0, len=4, gap=0), tready=1, repeat_cnt=0 → tvalid in cycles 2–5, tlast in cycle 5, `done` in cycle 6, pkt_cnt=1, beat_cnt=4.
- Slots 0/1 with len 2/3 and gap 5/0, repeat_cnt=1 → order 2,3,2,3 beats; exactly 5 idle cycles after each slot-0 packet; pkt_cnt=4.
- Same as case 1, with tready toggled 1-0-1-0 → all 4 beats delivered in order, each beat stable while stalled, stall_cnt equals the number of stalled cycles.
- Slot start=62, len=4, BEAT_DEPTH=64 → beats from addresses 62, 63, 0, 1.
- Slots 0/1 with len 4/2 and gap 0/0, `abort` during beat 1 of slot 0 → slot 0 completes with tlast, slot 1 is not played, then `done`; with `AXIS_PLAYER_SEQNUM_EN`, tuser[31:0]=0 on slot 0's first beat.
- `rst` asserted during beat 2 of 4 → next cycle tvalid=0, counters=0, busy=0; a following `start` replays from beat 0.
